// File: rtl/score_disp_sched.sv
// Score display scheduler: round-robin arbiter in front of one shared binary-to-BCD
// converter, three BCD slot registers and a multiplexed 3-digit display driver.
module score_disp_sched #(
  parameter int CONV_WAIT = 1,
  parameter int SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [7:0]  val0,
  input  logic [7:0]  val1,
  input  logic [7:0]  val2,
  output logic [2:0]  ack,
  output logic        busy,
  output logic [7:0]  conv_bin,
  input  logic [11:0] conv_bcd,
  input  logic [1:0]  disp_sel,
  output logic [2:0]  an,
  output logic [3:0]  digit
);

  typedef enum logic [1:0] {IDLE, LOAD, CAPTURE} state_t;

  localparam logic [3:0]  WAIT_LAST = 4'(CONV_WAIT - 1);
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      r_state, w_stateNext;
  logic [1:0]  r_lastGrant, r_grant, w_grantSel, w_probe;
  logic        w_grantFound, w_grantEn, w_captureEn;
  logic [3:0]  r_waitCnt;
  logic [7:0]  r_convBin, w_valSel;
  logic [11:0] r_slot0, r_slot1, r_slot2, w_dispSlot;
  logic [2:0]  r_ack, w_ackNext;
  logic [15:0] r_scanCnt;
  logic [1:0]  r_digIdx;
  logic [2:0]  r_an, w_anNext;
  logic [3:0]  r_digit, w_digitNext;

  function automatic logic [1:0] nextSlot(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // Search starts one past the last served slot, so a slot never wins twice while another waits.
  always_comb begin
    w_grantSel   = 2'd0;
    w_grantFound = 1'b0;
    w_probe      = nextSlot(r_lastGrant);
    for (int i = 0; i < 3; i++) begin
      if (!w_grantFound && req[w_probe]) begin
        w_grantSel   = w_probe;
        w_grantFound = 1'b1;
      end
      w_probe = nextSlot(w_probe);
    end
  end

  always_comb begin
    case (w_grantSel)
      2'd0:    w_valSel = val0;
      2'd1:    w_valSel = val1;
      2'd2:    w_valSel = val2;
      default: w_valSel = 8'd0;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    w_grantEn   = 1'b0;
    w_captureEn = 1'b0;
    w_ackNext   = 3'b000;
    case (r_state)
      IDLE: begin
        if (w_grantFound) begin
          w_grantEn   = 1'b1;
          w_stateNext = LOAD;
        end
      end
      LOAD: begin
        if (r_waitCnt == WAIT_LAST) w_stateNext = CAPTURE;
      end
      CAPTURE: begin
        w_captureEn = 1'b1;
        w_ackNext   = 3'b001 << r_grant;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // The operand is frozen at the grant edge; val changes afterwards are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= 2'd0;
      r_lastGrant <= 2'd2;
      r_convBin   <= 8'd0;
      r_waitCnt   <= 4'd0;
      r_slot0     <= 12'd0;
      r_slot1     <= 12'd0;
      r_slot2     <= 12'd0;
      r_ack       <= 3'b000;
    end else begin
      r_ack <= w_ackNext;
      if (w_grantEn) begin
        r_grant   <= w_grantSel;
        r_convBin <= w_valSel;
        r_waitCnt <= 4'd0;
      end else if (r_state == LOAD) begin
        r_waitCnt <= r_waitCnt + 4'd1;
      end
      if (w_captureEn) begin
        r_lastGrant <= r_grant;
        case (r_grant)
          2'd0:    r_slot0 <= conv_bcd;
          2'd1:    r_slot1 <= conv_bcd;
          2'd2:    r_slot2 <= conv_bcd;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (disp_sel)
      2'd0:    w_dispSlot = r_slot0;
      2'd1:    w_dispSlot = r_slot1;
      2'd2:    w_dispSlot = r_slot2;
      default: w_dispSlot = 12'd0;
    endcase
  end

  always_comb begin
    w_anNext    = 3'b111;
    w_digitNext = 4'd0;
    if (disp_sel != 2'd3) begin
      case (r_digIdx)
        2'd0: begin w_anNext = 3'b110; w_digitNext = w_dispSlot[3:0];  end
        2'd1: begin w_anNext = 3'b101; w_digitNext = w_dispSlot[7:4];  end
        2'd2: begin w_anNext = 3'b011; w_digitNext = w_dispSlot[11:8]; end
        default: ;
      endcase
    end
  end

  // Scan keeps running while blanked so the refresh phase is unaffected by disp_sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scanCnt <= 16'd0;
      r_digIdx  <= 2'd0;
      r_an      <= 3'b111;
      r_digit   <= 4'd0;
    end else begin
      r_an    <= w_anNext;
      r_digit <= w_digitNext;
      if (r_scanCnt == SCAN_LAST) begin
        r_scanCnt <= 16'd0;
        r_digIdx  <= (r_digIdx == 2'd2) ? 2'd0 : r_digIdx + 2'd1;
      end else begin
        r_scanCnt <= r_scanCnt + 16'd1;
      end
    end
  end

  assign ack      = r_ack;
  assign busy     = (r_state != IDLE);
  assign conv_bin = r_convBin;
  assign an       = r_an;
  assign digit    = r_digit;

endmodule

// File: tb/tb_score_disp_sched.sv
// Directed bench for score_disp_sched with a behavioural binary-to-BCD converter.
module tb_score_disp_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [7:0]  val0, val1, val2;
  logic [2:0]  ack;
  logic        busy;
  logic [7:0]  conv_bin;
  logic [11:0] conv_bcd;
  logic [1:0]  disp_sel;
  logic [2:0]  an;
  logic [3:0]  digit;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] bin2bcd(input logic [7:0] v);
    int n;
    n = int'(v);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  assign conv_bcd = bin2bcd(conv_bin);

  score_disp_sched #(.CONV_WAIT(1), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .val0(val0), .val1(val1), .val2(val2),
    .ack(ack), .busy(busy), .conv_bin(conv_bin), .conv_bcd(conv_bcd),
    .disp_sel(disp_sel), .an(an), .digit(digit)
  );

  // Reassembles a slot register from the scanned digits; unfinished reads leave X.
  task automatic readSlot(input logic [1:0] sel, output logic [11:0] value);
    logic [2:0] got;
    value    = 12'hxxx;
    got      = 3'b000;
    disp_sel = sel;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 40 && got != 3'b111; i++) begin
      case (an)
        3'b110: begin value[3:0]  = digit; got[0] = 1'b1; end
        3'b101: begin value[7:4]  = digit; got[1] = 1'b1; end
        3'b011: begin value[11:8] = digit; got[2] = 1'b1; end
        default: ;
      endcase
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b000; val0 = 8'd0; val1 = 8'd0; val2 = 8'd0; disp_sel = 2'd0;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 3'b000) begin failures++; $display("[TB] FAIL reset_ack actual=%b expected=000", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b expected=0", busy); end
    checks++; if (conv_bin !== 8'd0) begin failures++; $display("[TB] FAIL reset_conv_bin actual=%0d expected=0", conv_bin); end
    checks++; if (an !== 3'b111) begin failures++; $display("[TB] FAIL reset_an actual=%b expected=111", an); end
    checks++; if (digit !== 4'd0) begin failures++; $display("[TB] FAIL reset_digit actual=%0d expected=0", digit); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_req_busy actual=%b expected=0", busy); end
  endtask

  task automatic test_single();
    logic [11:0] v;
    @(negedge clk); val1 = 8'd173; req = 3'b010;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_load actual=%b expected=1", busy); end
    checks++; if (conv_bin !== 8'd173) begin failures++; $display("[TB] FAIL single_conv_bin actual=%0d expected=173", conv_bin); end
    checks++; if (ack !== 3'b000) begin failures++; $display("[TB] FAIL single_ack_early actual=%b expected=000", ack); end
    req = 3'b000;
    @(negedge clk);
    checks++; if ({busy, ack} !== 4'b1000) begin failures++; $display("[TB] FAIL single_capture busy_ack actual=%b expected=1000", {busy, ack}); end
    @(negedge clk);
    checks++; if ({busy, ack} !== 4'b0010) begin failures++; $display("[TB] FAIL single_ack busy_ack actual=%b expected=0010", {busy, ack}); end
    @(negedge clk);
    checks++; if (ack !== 3'b000) begin failures++; $display("[TB] FAIL single_ack_pulse actual=%b expected=000", ack); end
    readSlot(2'd1, v);
    checks++; if (v !== 12'h173) begin failures++; $display("[TB] FAIL single_slot1 actual=%h expected=173", v); end
  endtask

  task automatic test_contention();
    logic found;
    @(negedge clk);
    rst_n = 1'b0; req = 3'b111; val0 = 8'd42; val1 = 8'd17; val2 = 8'd200;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL contention_no_grant_before_edge busy=%b expected=0", busy); end
    for (int n = 0; n < 3; n++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        if (ack !== 3'b000) found = 1'b1;
      end
      checks++; if (ack !== (3'b001 << n)) begin failures++; $display("[TB] FAIL contention_ack%0d actual=%b expected=%b", n, ack, 3'b001 << n); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL contention_idle%0d busy=%b expected=0", n, busy); end
      req = req & ~ack;
      if (n < 2) begin
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL contention_regrant%0d busy=%b expected=1", n, busy); end
      end
    end
    req = 3'b000;
  endtask

  task automatic test_fairness();
    logic found;
    logic [2:0] expAck;
    logic [11:0] v;
    @(negedge clk); req = 3'b011;
    for (int n = 0; n < 4; n++) begin
      expAck = (n % 2 == 0) ? 3'b001 : 3'b010;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        if (ack !== 3'b000) found = 1'b1;
      end
      checks++; if (ack !== expAck) begin failures++; $display("[TB] FAIL fairness_ack%0d actual=%b expected=%b", n, ack, expAck); end
    end
    req = 3'b000;
    readSlot(2'd1, v);
    checks++; if (v !== 12'h017) begin failures++; $display("[TB] FAIL fairness_slot1 actual=%h expected=017", v); end
  endtask

  task automatic test_operand_stability();
    logic found;
    logic [11:0] v;
    @(negedge clk); val2 = 8'd255; req = 3'b100;
    @(negedge clk);
    checks++; if (conv_bin !== 8'd255) begin failures++; $display("[TB] FAIL stability_grant_bin actual=%0d expected=255", conv_bin); end
    val2 = 8'd7; req = 3'b000;
    @(negedge clk);
    checks++; if (conv_bin !== 8'd255) begin failures++; $display("[TB] FAIL stability_held_bin actual=%0d expected=255", conv_bin); end
    found = (ack !== 3'b000);
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (ack !== 3'b000) found = 1'b1;
    end
    checks++; if (ack !== 3'b100) begin failures++; $display("[TB] FAIL stability_ack actual=%b expected=100", ack); end
    readSlot(2'd2, v);
    checks++; if (v !== 12'h255) begin failures++; $display("[TB] FAIL stability_slot2 actual=%h expected=255", v); end
  endtask

  task automatic test_display();
    logic [2:0] prev, expAn;
    logic [3:0] expDig;
    logic found;
    disp_sel = 2'd0;
    @(negedge clk);
    prev  = an;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (an === 3'b110 && prev === 3'b011) found = 1'b1;
      else prev = an;
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL display_sync an=%b expected=110 after 011", an); end
    for (int d = 0; d < 3; d++) begin
      case (d)
        0:       begin expAn = 3'b110; expDig = 4'd2; end
        1:       begin expAn = 3'b101; expDig = 4'd4; end
        default: begin expAn = 3'b011; expDig = 4'd0; end
      endcase
      for (int s = 0; s < 4; s++) begin
        checks++; if ({an, digit} !== {expAn, expDig}) begin failures++; $display("[TB] FAIL display_scan d%0d s%0d an_digit actual=%b/%0d expected=%b/%0d", d, s, an, digit, expAn, expDig); end
        @(negedge clk);
      end
    end
    disp_sel = 2'd3;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      checks++; if ({an, digit} !== 7'b111_0000) begin failures++; $display("[TB] FAIL display_blank s%0d an_digit actual=%b/%0d expected=111/0", s, an, digit); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_load();
    logic found;
    logic [11:0] v;
    disp_sel = 2'd0;
    @(negedge clk); val0 = 8'd99; req = 3'b001;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rstload_in_load busy=%b expected=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ack, busy} !== 4'b0000) begin failures++; $display("[TB] FAIL rstload_ack_busy actual=%b expected=0000", {ack, busy}); end
    checks++; if (conv_bin !== 8'd0) begin failures++; $display("[TB] FAIL rstload_conv_bin actual=%0d expected=0", conv_bin); end
    checks++; if ({an, digit} !== 7'b111_0000) begin failures++; $display("[TB] FAIL rstload_display actual=%b/%0d expected=111/0", an, digit); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (ack !== 3'b000) begin failures++; $display("[TB] FAIL rstload_no_ack%0d actual=%b expected=000", c, ack); end
    end
    rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (ack !== 3'b000) found = 1'b1;
    end
    checks++; if (ack !== 3'b001) begin failures++; $display("[TB] FAIL rstload_next_ack actual=%b expected=001", ack); end
    req = 3'b000;
    readSlot(2'd0, v);
    checks++; if (v !== 12'h099) begin failures++; $display("[TB] FAIL rstload_slot0 actual=%h expected=099", v); end
    readSlot(2'd1, v);
    checks++; if (v !== 12'h000) begin failures++; $display("[TB] FAIL rstload_slot1_cleared actual=%h expected=000", v); end
    readSlot(2'd2, v);
    checks++; if (v !== 12'h000) begin failures++; $display("[TB] FAIL rstload_slot2_cleared actual=%h expected=000", v); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_operand_stability();
    test_display();
    test_reset_in_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
